// File: rtl/icpu_pkg.sv
// Shared types and constants for the ICPU graph execution stage.
package icpu_pkg;

    localparam int unsigned NODES    = 16;
    localparam int unsigned NODE_W   = $clog2(NODES);
    localparam int unsigned MAX_HOPS = 16;
    localparam int unsigned HW       = $clog2(MAX_HOPS + 1);

    localparam logic [3:0] OP_NEW  = 4'b0001;
    localparam logic [3:0] OP_LINK = 4'b0010;
    localparam logic [3:0] OP_EVAL = 4'b0101;

    typedef logic [NODE_W-1:0] node_idx_t;

    typedef enum logic [1:0] {
        RspOk       = 2'd0,
        RspNop      = 2'd1,
        RspErrDead  = 2'd2,
        RspErrCycle = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        StIdle,
        StWalk,
        StResp
    } state_e;

endpackage

// File: rtl/icpu_node_table.sv
// Node table: alive/has_link/link per node, one write port, three async read ports.
module icpu_node_table
    import icpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      new_en_i,
    input  logic      link_en_i,
    input  node_idx_t wr_idx_i,
    input  node_idx_t wr_link_i,
    input  node_idx_t dest_idx_i,
    input  node_idx_t src1_idx_i,
    input  node_idx_t cur_idx_i,
    output logic      dest_alive_o,
    output logic      src1_alive_o,
    output logic      cur_has_link_o,
    output node_idx_t cur_link_o
);

    logic [NODES-1:0]      alive_q, alive_d;
    logic [NODES-1:0]      has_link_q, has_link_d;
    node_idx_t [NODES-1:0] link_q, link_d;

    // NEW clears the outgoing link only; links pointing into the node survive.
    always_comb begin
        alive_d    = alive_q;
        has_link_d = has_link_q;
        link_d     = link_q;
        if (new_en_i) begin
            alive_d[wr_idx_i]    = 1'b1;
            has_link_d[wr_idx_i] = 1'b0;
        end else if (link_en_i) begin
            has_link_d[wr_idx_i] = 1'b1;
            link_d[wr_idx_i]     = wr_link_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q    <= '0;
            has_link_q <= '0;
            link_q     <= '0;
        end else begin
            alive_q    <= alive_d;
            has_link_q <= has_link_d;
            link_q     <= link_d;
        end
    end

    assign dest_alive_o   = alive_q[dest_idx_i];
    assign src1_alive_o   = alive_q[src1_idx_i];
    assign cur_has_link_o = has_link_q[cur_idx_i];
    assign cur_link_o     = link_q[cur_idx_i];

endmodule

// File: rtl/icpu_graph_exec.sv
// ICPU execution stage: runs NEW/LINK/EVAL against the node table, one response per instruction.
module icpu_graph_exec
    import icpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    opcode,
    input  logic [3:0]    dest,
    input  logic [3:0]    src1,
    input  logic [3:0]    src2,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_status,
    output logic [3:0]    rsp_node,
    output logic [HW-1:0] rsp_hops
);

    state_e         state_q, state_d;
    node_idx_t      cur_q, cur_d;
    logic [HW-1:0]  hops_q, hops_d;
    status_e        status_q, status_d;
    node_idx_t      node_q, node_d;
    logic [HW-1:0]  rhops_q, rhops_d;

    logic      new_en, link_en;
    logic      dest_alive, src1_alive, cur_has_link;
    node_idx_t cur_link;
    logic      unused_src2;

    assign unused_src2 = ^src2;

    icpu_node_table u_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_en_i       (new_en),
        .link_en_i      (link_en),
        .wr_idx_i       (dest),
        .wr_link_i      (src1),
        .dest_idx_i     (dest),
        .src1_idx_i     (src1),
        .cur_idx_i      (cur_q),
        .dest_alive_o   (dest_alive),
        .src1_alive_o   (src1_alive),
        .cur_has_link_o (cur_has_link),
        .cur_link_o     (cur_link)
    );

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        hops_d   = hops_q;
        status_d = status_q;
        node_d   = node_q;
        rhops_d  = rhops_q;
        new_en   = 1'b0;
        link_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    node_d  = dest;
                    rhops_d = '0;
                    state_d = StResp;
                    case (opcode)
                        OP_NEW: begin
                            new_en   = 1'b1;
                            status_d = RspOk;
                        end
                        OP_LINK: begin
                            if (dest_alive && src1_alive) begin
                                link_en  = 1'b1;
                                status_d = RspOk;
                            end else begin
                                status_d = RspErrDead;
                            end
                        end
                        OP_EVAL: begin
                            if (!dest_alive) begin
                                status_d = RspErrDead;
                            end else begin
                                cur_d   = dest;
                                hops_d  = '0;
                                state_d = StWalk;
                            end
                        end
                        default: status_d = RspNop;
                    endcase
                end
            end
            StWalk: begin
                // One table read per cycle; the hop limit is checked before following a link.
                if (!cur_has_link) begin
                    status_d = RspOk;
                    node_d   = cur_q;
                    rhops_d  = hops_q;
                    state_d  = StResp;
                end else if (hops_q == HW'(MAX_HOPS)) begin
                    status_d = RspErrCycle;
                    node_d   = cur_q;
                    rhops_d  = hops_q;
                    state_d  = StResp;
                end else begin
                    cur_d  = cur_link;
                    hops_d = hops_q + HW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cur_q    <= '0;
            hops_q   <= '0;
            status_q <= RspOk;
            node_q   <= '0;
            rhops_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            hops_q   <= hops_d;
            status_q <= status_d;
            node_q   <= node_d;
            rhops_q  <= rhops_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_status = status_q;
    assign rsp_node   = node_q;
    assign rsp_hops   = rhops_q;

endmodule

// File: tb/tb_icpu_graph_exec.sv
// Randomized self-checking bench for icpu_graph_exec against a behavioural graph model.
module tb_icpu_graph_exec;
    import icpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [3:0]    dest;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [3:0]    rsp_node;
    logic [HW-1:0] rsp_hops;

    int n_checks = 0;
    int n_errors = 0;

    // Reference graph state
    bit m_alive[16];
    bit m_has_link[16];
    int m_link[16];

    always #5 clk = ~clk;

    icpu_graph_exec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .dest       (dest),
        .src1       (src1),
        .src2       (src2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_node   (rsp_node),
        .rsp_hops   (rsp_hops)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_alive[i]    = 1'b0;
            m_has_link[i] = 1'b0;
            m_link[i]     = 0;
        end
    endtask

    // Applies one instruction to the model; returns expected response and cycle latency.
    task automatic model_exec(input int op, input int d, input int s,
                              output int st, output int node, output int hops, output int lat);
        int cur;
        st   = 1;
        node = d;
        hops = 0;
        lat  = 1;
        if (op == int'(OP_NEW)) begin
            m_alive[d]    = 1'b1;
            m_has_link[d] = 1'b0;
            st = 0;
        end else if (op == int'(OP_LINK)) begin
            if (m_alive[d] && m_alive[s]) begin
                m_link[d]     = s;
                m_has_link[d] = 1'b1;
                st = 0;
            end else begin
                st = 2;
            end
        end else if (op == int'(OP_EVAL)) begin
            if (!m_alive[d]) begin
                st = 2;
            end else begin
                cur = d;
                while (1) begin
                    if (!m_has_link[cur]) begin
                        st = 0;
                        break;
                    end
                    if (hops == int'(MAX_HOPS)) begin
                        st = 3;
                        break;
                    end
                    cur = m_link[cur];
                    hops++;
                end
                node = cur;
                lat  = hops + 2;
            end
        end
    endtask

    task automatic do_op(input int op, input int d, input int s, input int hold);
        int exp_st, exp_node, exp_hops, exp_lat, lat;
        model_exec(op, d, s, exp_st, exp_node, exp_hops, exp_lat);
        @(negedge clk);
        check_eq("in_ready_before_issue", int'(in_ready), 1);
        in_valid = 1'b1;
        opcode   = 4'(op);
        dest     = 4'(d);
        src1     = 4'(s);
        src2     = 4'($urandom);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        check_eq("latency", lat, exp_lat);
        if (rsp_valid) begin
            check_eq("status", int'(rsp_status), exp_st);
            check_eq("node", int'(rsp_node), exp_node);
            check_eq("hops", int'(rsp_hops), exp_hops);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("hold_valid", int'(rsp_valid), 1);
                check_eq("hold_status", int'(rsp_status), exp_st);
                check_eq("hold_node", int'(rsp_node), exp_node);
                check_eq("hold_hops", int'(rsp_hops), exp_hops);
                check_eq("hold_in_ready", int'(in_ready), 0);
                // Upstream pokes while busy must not be accepted
                in_valid = 1'($urandom_range(0, 1));
                opcode   = OP_NEW;
                dest     = 4'($urandom);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            check_eq("rsp_valid_after_take", int'(rsp_valid), 0);
            check_eq("in_ready_after_take", int'(in_ready), 1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op, d, s, r, lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        dest      = '0;
        src1      = '0;
        src2      = '0;
        rsp_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_in_ready", int'(in_ready), 1);
        check_eq("reset_rsp_valid", int'(rsp_valid), 0);
        check_eq("reset_status", int'(rsp_status), 0);
        check_eq("reset_node", int'(rsp_node), 0);
        check_eq("reset_hops", int'(rsp_hops), 0);

        do_op(int'(OP_EVAL), 3, 0, 0);
        do_op(15, 2, 0, 1);

        do_op(int'(OP_NEW), 1, 0, 0);
        do_op(int'(OP_NEW), 2, 0, 0);
        do_op(int'(OP_NEW), 3, 0, 0);
        do_op(int'(OP_LINK), 1, 2, 0);
        do_op(int'(OP_LINK), 2, 3, 0);
        do_op(int'(OP_EVAL), 1, 0, 0);

        do_op(int'(OP_NEW), 5, 0, 0);
        do_op(int'(OP_LINK), 5, 5, 0);
        do_op(int'(OP_EVAL), 5, 0, 5);

        do_op(int'(OP_NEW), 4, 0, 0);
        do_op(int'(OP_LINK), 4, 6, 0);
        do_op(int'(OP_EVAL), 4, 0, 0);
        do_op(int'(OP_NEW), 3, 0, 0);
        do_op(int'(OP_EVAL), 2, 0, 0);
        do_op(int'(OP_EVAL), 9, 0, 0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = int'(OP_NEW);
            else if (r < 6) op = int'(OP_LINK);
            else if (r < 9) op = int'(OP_EVAL);
            else            op = $urandom_range(0, 15);
            d = $urandom_range(0, 7);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
            do_op(op, d, s, $urandom_range(0, 3));
        end

        // Build a 10-hop chain 0->1->...->10 and reset during its walk
        for (int i = 0; i <= 10; i++) do_op(int'(OP_NEW), i, 0, 0);
        for (int i = 0; i < 10; i++) do_op(int'(OP_LINK), i, i + 1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = OP_EVAL;
        dest     = 4'd0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("walk_busy_in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check_eq("midwalk_rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("midwalk_rst_in_ready", int'(in_ready), 1);
        check_eq("midwalk_rst_status", int'(rsp_status), 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
        end
        check_eq("dropped_rsp_count", lat, 0);
        do_op(int'(OP_EVAL), $urandom_range(0, 15), 0, 0);
        do_op(int'(OP_EVAL), 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icpu_graph_exec.md
# icpu_graph_exec

Execution stage of the ICPU, directly downstream of the instruction decoder. It accepts decoded fields (opcode, dest, src1, src2) over a valid/ready handshake and owns the node table. It executes NEW, LINK and EVAL against that table; EVAL is a multi-cycle pointer walk. Every accepted instruction returns exactly one response: a status, a result node and a hop count.

## Interface
- NODES, 16: node-table entries; node index width is clog2(NODES), 4 at default.
- MAX_HOPS, 16: EVAL hop limit; HW = clog2(MAX_HOPS+1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept.
- opcode  in  4  decoded opcode.
- dest  in  4  destination node.
- src1  in  4  source node 1.
- src2  in  4  source node 2; unused, reserved.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_status  out  2  OK=0, NOP=1, ERR_DEAD=2, ERR_CYCLE=3.
- rsp_node  out  4  result node.
- rsp_hops  out  HW  hops taken by EVAL; 0 for every other opcode.

## Operation
- Node table, per entry: alive, has_link, link[3:0].
- States: IDLE, WALK, RESP. in_ready = (state==IDLE); rsp_valid = (state==RESP).
- Accept = in_valid & in_ready. On accept:
  - NEW (0001): alive[dest]=1, has_link[dest]=0 → RESP, OK, node=dest. Re-NEW of a live node resets its link. Links from other nodes into dest are untouched.
  - LINK (0010): if alive[dest] & alive[src1], set link[dest]=src1 and has_link[dest]=1 → RESP, OK, node=dest. Otherwise → RESP, ERR_DEAD, table unchanged. Self-link is allowed.
  - EVAL (0101): if !alive[dest] → RESP, ERR_DEAD, node=dest. Otherwise cur=dest, hops=0 → WALK.
  - Any other opcode → RESP, NOP, node=dest, table unchanged.
- WALK, one table read per cycle:
  - !has_link[cur] → RESP, OK, node=cur.
  - has_link[cur] & hops==MAX_HOPS → RESP, ERR_CYCLE, node=cur.
  - Otherwise cur=link[cur], hops=hops+1.
- EVAL does not re-check alive on traversed nodes; a link into a node stays valid as recorded.
- RESP: outputs are held stable until rsp_ready. On rsp_ready → IDLE.
- hops never exceeds MAX_HOPS; no wrap.

## Timing
- Reset (async, immediate): state=IDLE, whole table cleared (all dead), rsp_valid=0, rsp_status=0, rsp_node=0, rsp_hops=0. in_ready=1 from the first cycle after deassertion.
- Non-walk ops (NEW, LINK, NOP, any error at accept): table write and response register on the accept edge. rsp_valid is high in the next cycle (latency 1).
- EVAL with k hops to terminal: latency k+2 cycles from the accept edge to rsp_valid. The ERR_CYCLE case takes MAX_HOPS+2 cycles.
- Response handoff takes 1 cycle: RESP exits on the rsp_ready edge, and in_ready rises the cycle after. There is no same-cycle bypass, so at most one instruction is in flight.
- in_valid while busy: ignored. The upstream stage holds its fields.
- Reset mid-WALK or mid-RESP: the pending response is dropped; no response is emitted.

## Structure
- icpu_pkg holds:
  - opcode constants OP_NEW=4'b0001, OP_LINK=4'b0010, OP_EVAL=4'b0101;
  - status enum;
  - state enum;
  - node index type.
- Sub-module icpu_node_table:
  - alive/has_link/link registers;
  - one synchronous write port (set-alive, set-link);
  - three asynchronous read ports (dest, src1, cur);
  - async clear on rst_n.
- The FSM, walk counter and response registers stay in icpu_graph_exec.

## Test plan
- After reset, EVAL dest=3 → ERR_DEAD, node=3, hops=0, latency 1. Opcode 0xF dest=2 → NOP, node=2.
- NEW 1, NEW 2, NEW 3, LINK 1→2, LINK 2→3, then EVAL 1 → OK, node=3, hops=2, rsp_valid 4 cycles after accept.
- NEW 5, LINK 5→5, EVAL 5 → ERR_CYCLE, node=5, hops=16, latency 18.
- NEW 4, LINK 4→6 with node 6 dead → ERR_DEAD. Then EVAL 4 → OK, node=4, hops=0. NEW 3 after LINK 2→3 leaves node 2's link intact.
- Hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_status, rsp_node and rsp_hops stable, and in_ready=0 throughout. in_valid pulses in that window are not accepted.
- Assert rst_n=0 during the WALK of a 10-hop chain → rsp_valid=0 immediately. After release, EVAL of any node → ERR_DEAD.
